// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: owns the PC and instruction register and steps each
// instruction through fetch/decode/execute/memory/writeback with Moore control strobes.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic [5:0]       pc,
  output logic [31:0]      ir,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             mem_re,
  output logic             mem_we,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  state_t           state_q, state_d;
  logic [5:0]       pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    case (state_q)
      S_FETCH: begin
        if (run) begin
          ir_d    = instr;
          pc_d    = pc_q + 6'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (ir_q[31:26])
          OP_RTYPE:      state_d = S_EXEC_R;
          OP_ADDI:       state_d = S_EXEC_I;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_HALT:       state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_WB_R:     state_d = S_FETCH;
      S_EXEC_I:   state_d = S_WB_I;
      S_WB_I:     state_d = S_FETCH;
      S_MEM_ADDR: state_d = (ir_q[31:26] == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_BRANCH: begin
        // pc already points past the branch; offset wraps mod 64
        if (alu_zero) pc_d = pc_q + ir_q[5:0];
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = ir_q[5:0];
        state_d = S_FETCH;
      end
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
    if (state_q != S_FETCH && state_d == S_FETCH)
      retired_d = retired_q + CNT_W'(1);
  end

  always_comb begin
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = 2'b00;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      S_EXEC_R: alu_op = 2'b10;
      S_WB_R: begin
        alu_op  = 2'b10;
        reg_we  = 1'b1;
        reg_dst = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: alu_src_b = 1'b1;
      S_WB_I: begin
        alu_src_b = 1'b1;
        reg_we    = 1'b1;
      end
      S_MEM_RD: begin
        alu_src_b = 1'b1;
        mem_re    = 1'b1;
      end
      S_MEM_WB: begin
        alu_src_b  = 1'b1;
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        alu_src_b = 1'b1;
        mem_we    = 1'b1;
      end
      S_BRANCH: alu_op = 2'b01;
      default: ;
    endcase
  end

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign retired = retired_q;
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver queues the expected Moore outputs of
// each cycle, and a monitor compares them against the DUT at the falling edge.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [31:0] instr = '0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [5:0]  pc;
  logic [31:0] ir;
  logic        reg_we, reg_dst, mem_to_reg, alu_src_b, mem_re, mem_we, halted, illegal;
  logic [1:0]  alu_op;
  logic [15:0] retired;

  multicycle_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .pc(pc), .ir(ir), .reg_we(reg_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_re(mem_re),
    .mem_we(mem_we), .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  // ctl = {reg_we, reg_dst, mem_to_reg, alu_src_b, alu_op[1:0], mem_re, mem_we, halted, illegal}
  localparam logic [9:0] IDLE  = 10'b0000000000;
  localparam logic [9:0] EXR   = 10'b0000100000;
  localparam logic [9:0] WBR   = 10'b1100100000;
  localparam logic [9:0] EXI   = 10'b0001000000;
  localparam logic [9:0] MADDR = 10'b0001000000;
  localparam logic [9:0] WBI   = 10'b1001000000;
  localparam logic [9:0] MRD   = 10'b0001001000;
  localparam logic [9:0] MWB   = 10'b1011000000;
  localparam logic [9:0] MWR   = 10'b0001000100;
  localparam logic [9:0] BR    = 10'b0000010000;
  localparam logic [9:0] HLTC  = 10'b0000000010;
  localparam logic [9:0] HLTI  = 10'b0000000011;

  localparam logic [31:0] R    = 32'h00221820;
  localparam logic [31:0] LW   = 32'h8C220004;
  localparam logic [31:0] SW   = 32'hAC220008;
  localparam logic [31:0] ADDI = 32'h20220005;
  localparam logic [31:0] J5   = 32'h08000005;
  localparam logic [31:0] BEQ  = 32'h1000003E;
  localparam logic [31:0] J63  = 32'h0800003F;
  localparam logic [31:0] ILL  = 32'hE8000000;
  localparam logic [31:0] HLT  = 32'hFC000000;

  typedef struct {
    string       name;
    logic [5:0]  pc;
    logic [31:0] ir;
    logic [9:0]  ctl;
    logic [15:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic step(input logic rst, input logic r, input logic [31:0] ins,
                      input logic az, input logic mr, input string nm,
                      input logic [5:0] epc, input logic [31:0] eir,
                      input logic [9:0] ectl, input logic [15:0] eret);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    run       = r;
    instr     = ins;
    alu_zero  = az;
    mem_ready = mr;
    e.name = nm; e.pc = epc; e.ir = eir; e.ctl = ectl; e.ret = eret;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [9:0]  ctl;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        ctl = {reg_we, reg_dst, mem_to_reg, alu_src_b, alu_op, mem_re, mem_we, halted, illegal};
        checks += 4;
        if (pc !== e.pc) begin
          errors++;
          $display("FAIL %s pc: got %0d expected %0d", e.name, pc, e.pc);
        end
        if (ir !== e.ir) begin
          errors++;
          $display("FAIL %s ir: got %h expected %h", e.name, ir, e.ir);
        end
        if (ctl !== e.ctl) begin
          errors++;
          $display("FAIL %s ctl: got %b expected %b", e.name, ctl, e.ctl);
        end
        if (retired !== e.ret) begin
          errors++;
          $display("FAIL %s retired: got %0d expected %0d", e.name, retired, e.ret);
        end
        $display("check %s pc=%0d ir=%h ctl=%b retired=%0d", e.name, pc, ir, ctl, retired);
      end
    end
  end

  initial begin : driver
    int wait_cycles;
    #1 reset = 1'b1;
    // R-type from pc 0
    step(1, 1, R,    0, 0, "reset",        0,  '0,   IDLE,  0);
    step(0, 1, R,    0, 0, "r_fetch",      0,  '0,   IDLE,  0);
    step(0, 0, '0,   0, 1, "r_decode",     1,  R,    IDLE,  0);
    step(0, 0, '0,   0, 1, "r_exec",       1,  R,    EXR,   0);
    step(0, 0, '0,   0, 1, "r_wb",         1,  R,    WBR,   0);
    // lw with two wait states
    step(0, 1, LW,   0, 1, "lw_fetch",     1,  R,    IDLE,  1);
    step(0, 0, '0,   0, 1, "lw_decode",    2,  LW,   IDLE,  1);
    step(0, 0, '0,   0, 0, "lw_addr",      2,  LW,   MADDR, 1);
    step(0, 0, '0,   0, 0, "lw_rd0",       2,  LW,   MRD,   1);
    step(0, 0, '0,   0, 0, "lw_rd1",       2,  LW,   MRD,   1);
    step(0, 0, '0,   0, 1, "lw_rd2",       2,  LW,   MRD,   1);
    step(0, 0, '0,   0, 0, "lw_wb",        2,  LW,   MWB,   1);
    // sw with no wait state
    step(0, 1, SW,   0, 0, "sw_fetch",     2,  LW,   IDLE,  2);
    step(0, 0, '0,   0, 0, "sw_decode",    3,  SW,   IDLE,  2);
    step(0, 0, '0,   0, 1, "sw_addr",      3,  SW,   MADDR, 2);
    step(0, 0, '0,   0, 1, "sw_wr",        3,  SW,   MWR,   2);
    // addi
    step(0, 1, ADDI, 0, 0, "addi_fetch",   3,  SW,   IDLE,  3);
    step(0, 0, '0,   0, 0, "addi_decode",  4,  ADDI, IDLE,  3);
    step(0, 0, '0,   0, 0, "addi_exec",    4,  ADDI, EXI,   3);
    step(0, 0, '0,   0, 0, "addi_wb",      4,  ADDI, WBI,   3);
    // jump to 5, taken beq back to 4
    step(0, 1, J5,   0, 0, "j5_fetch",     4,  ADDI, IDLE,  4);
    step(0, 0, '0,   0, 0, "j5_decode",    5,  J5,   IDLE,  4);
    step(0, 0, '0,   0, 0, "j5_jump",      5,  J5,   IDLE,  4);
    step(0, 1, BEQ,  0, 0, "beq_fetch",    5,  J5,   IDLE,  5);
    step(0, 0, '0,   0, 0, "beq_decode",   6,  BEQ,  IDLE,  5);
    step(0, 0, '0,   1, 0, "beq_taken",    6,  BEQ,  BR,    5);
    // back to 5, not-taken beq
    step(0, 1, J5,   0, 0, "beq_t_fetch",  4,  BEQ,  IDLE,  6);
    step(0, 0, '0,   0, 0, "j5b_decode",   5,  J5,   IDLE,  6);
    step(0, 0, '0,   0, 0, "j5b_jump",     5,  J5,   IDLE,  6);
    step(0, 1, BEQ,  0, 0, "beq2_fetch",   5,  J5,   IDLE,  7);
    step(0, 0, '0,   0, 0, "beq2_decode",  6,  BEQ,  IDLE,  7);
    step(0, 0, '0,   0, 1, "beq_ntaken",   6,  BEQ,  BR,    7);
    // jump to 63, stall with run=0, then wrap
    step(0, 1, J63,  0, 0, "beq_nt_fetch", 6,  BEQ,  IDLE,  8);
    step(0, 0, '0,   0, 0, "j63_decode",   7,  J63,  IDLE,  8);
    step(0, 0, '0,   0, 0, "j63_jump",     7,  J63,  IDLE,  8);
    step(0, 0, R,    0, 1, "stall0",       63, J63,  IDLE,  9);
    step(0, 0, R,    0, 1, "stall1",       63, J63,  IDLE,  9);
    step(0, 0, R,    0, 1, "stall2",       63, J63,  IDLE,  9);
    step(0, 1, R,    0, 0, "wrap_fetch",   63, J63,  IDLE,  9);
    step(0, 0, '0,   0, 0, "wrap_decode",  0,  R,    IDLE,  9);
    step(0, 0, '0,   0, 0, "wrap_exec",    0,  R,    EXR,   9);
    step(0, 0, '0,   0, 0, "wrap_wb",      0,  R,    WBR,   9);
    // reset during a memory read wait
    step(0, 1, LW,   0, 0, "lw2_fetch",    0,  R,    IDLE,  10);
    step(0, 0, '0,   0, 0, "lw2_decode",   1,  LW,   IDLE,  10);
    step(0, 0, '0,   0, 0, "lw2_addr",     1,  LW,   MADDR, 10);
    step(0, 0, '0,   0, 0, "lw2_rd",       1,  LW,   MRD,   10);
    step(1, 1, ADDI, 0, 0, "rst_mid_mem",  0,  '0,   IDLE,  0);
    step(0, 1, ADDI, 0, 0, "post_rst",     0,  '0,   IDLE,  0);
    step(0, 0, '0,   0, 0, "addi2_decode", 1,  ADDI, IDLE,  0);
    step(0, 0, '0,   0, 0, "addi2_exec",   1,  ADDI, EXI,   0);
    step(0, 0, '0,   0, 0, "addi2_wb",     1,  ADDI, WBI,   0);
    // illegal opcode 0x3A
    step(0, 1, ILL,  0, 1, "ill_fetch",    1,  ADDI, IDLE,  1);
    step(0, 1, R,    1, 1, "ill_decode",   2,  ILL,  IDLE,  1);
    step(0, 1, R,    1, 1, "ill_halt0",    2,  ILL,  HLTI,  1);
    step(0, 1, R,    1, 1, "ill_halt1",    2,  ILL,  HLTI,  1);
    step(0, 1, R,    1, 1, "ill_halt2",    2,  ILL,  HLTI,  1);
    // explicit halt 0x3F
    step(1, 1, HLT,  0, 0, "rst_halt",     0,  '0,   IDLE,  0);
    step(0, 1, HLT,  0, 0, "hlt_fetch",    0,  '0,   IDLE,  0);
    step(0, 1, R,    1, 1, "hlt_decode",   1,  HLT,  IDLE,  0);
    step(0, 1, R,    1, 1, "hlt_halt0",    1,  HLT,  HLTC,  0);
    step(0, 1, R,    1, 1, "hlt_halt1",    1,  HLT,  HLTC,  0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the processor datapath. It owns the 6-bit program counter and latches the fetched instruction into an instruction register. It steps each instruction through fetch, decode, execute, memory and writeback states, driving one-hot-in-time control strobes to the register file, ALU and data memory. It replaces single-cycle combinational control, and lets the data memory take a variable number of cycles through a ready handshake.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- run  in  1  permit to start a new instruction; sampled in FETCH only
- instr  in  32  instruction-memory read data at address pc
- alu_zero  in  1  ALU zero flag, valid in BRANCH
- mem_ready  in  1  data memory access complete, sampled in MEM_RD/MEM_WR
- pc  out  6  instruction word address
- ir  out  32  latched instruction
- reg_we  out  1  register-file write strobe
- reg_dst  out  1  0: write rt (ir[20:16]), 1: write rd (ir[15:11])
- mem_to_reg  out  1  1: writeback data from memory, 0: from ALU
- alu_src_b  out  1  0: register rt, 1: sign-extended ir[15:0]
- alu_op  out  2  00 add, 01 sub, 10 decode by funct
- mem_re  out  1  data memory read request
- mem_we  out  1  data memory write request
- halted  out  1  sequencer stopped (sticky)
- illegal  out  1  stop caused by unknown opcode (sticky)
- retired  out  CNT_W  instructions completed, wraps modulo 2^CNT_W

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, WB_R, WB_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, HALT.
- FETCH: if run=1, ir <= instr, pc <= pc+1 (mod 64), go to DECODE. If run=0, stay; pc and ir hold.
- DECODE on ir[31:26]:
  - 000000 R-type -> EXEC_R
  - 001000 addi -> EXEC_I
  - 100011 lw, 101011 sw -> MEM_ADDR
  - 000100 beq -> BRANCH
  - 000010 j -> JUMP
  - 111111 halt -> HALT
  - anything else -> HALT with illegal set
- Path sequences:
  - EXEC_R -> WB_R -> FETCH
  - EXEC_I -> WB_I -> FETCH
  - MEM_ADDR -> MEM_RD (lw) or MEM_WR (sw)
  - MEM_RD -> MEM_WB when mem_ready=1, else stay; MEM_WB -> FETCH
  - MEM_WR -> FETCH when mem_ready=1, else stay
  - BRANCH and JUMP -> FETCH
- Output decode, Moore (from state and ir only); every strobe not listed is 0:
  - EXEC_R, WB_R: alu_op=10, alu_src_b=0; WB_R adds reg_we=1, reg_dst=1
  - EXEC_I, WB_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR: alu_op=00, alu_src_b=1
  - WB_I: reg_we=1, reg_dst=0
  - MEM_RD: mem_re=1
  - MEM_WB: reg_we=1, reg_dst=0, mem_to_reg=1
  - MEM_WR: mem_we=1
  - BRANCH: alu_op=01, alu_src_b=0
- BRANCH: if alu_zero=1, pc <= pc + ir[5:0], with pc already incremented; the addition is 6-bit two's-complement and wraps mod 64.
- JUMP: pc <= ir[5:0].
- retired increments by 1 on each transition into FETCH from an execution state. HALT entry does not count.
- HALT: all strobes 0, halted=1; no exit except reset. run is ignored.

## Timing
- Reset (async, any state, including mid-memory-wait): state=FETCH, pc=0, ir=0, retired=0, halted=0, illegal=0, all strobes 0.
- Latency with zero wait states, counted from FETCH cycle to next FETCH:
  - R-type, addi, sw: 4 cycles
  - lw: 5 cycles
  - beq, j: 3 cycles
- Each cycle mem_ready is low in MEM_RD or MEM_WR adds one cycle. mem_re/mem_we stay high continuously until the cycle mem_ready=1 is sampled, then drop.
- mem_ready is ignored outside MEM_RD/MEM_WR.
- reg_we is high for exactly one cycle per writing instruction.
- pc updates at the end of FETCH, BRANCH (taken) and JUMP only.

## Test plan
- Reset asserted mid-MEM_RD with mem_re=1 -> same instant: pc=0, mem_re=0, state FETCH; after release, FETCH of pc 0.
- R-type at pc 0 (instr=0x00221820), run=1 -> reg_we=1, reg_dst=1 in cycle 4 only; pc=1 from cycle 2; retired=1 after cycle 4.
- lw (0x8C220004) with mem_ready low for 2 cycles -> mem_re high 3 cycles; then one MEM_WB cycle with reg_we=1, mem_to_reg=1; 7 cycles total.
- beq at pc 5, ir[5:0]=0x3E, alu_zero=1 -> pc=4. Same instruction with alu_zero=0 -> pc=6.
- j to 63 (0x0800003F), then R-type at 63 -> pc wraps to 0 after fetch. run=0 in FETCH for 3 cycles -> pc and ir unchanged.
- Opcode 0x3A -> halted=1, illegal=1 permanently, no strobes, retired unchanged. Opcode 0x3F -> halted=1, illegal=0.
